// File: rtl/serial_mod_mult.sv
// serial_mod_mult: bit-serial GF(2)[x] multiplier modulo PQ, one product every 8+d iterations
`ifndef D
`define D 0
`endif
`ifndef PQ
`define PQ 9'b110110001
`endif

module modular_shift #(
  parameter int       W = 8,
  parameter bit [0:W] P = 9'b110110001
) (
  input  logic [0:W-1] i_a,
  output logic [0:W-1] o_y
);
  assign o_y = {1'b0, i_a[0:W-2]} ^ (i_a[W-1] ? P[0:W-1] : '0);
endmodule

module serial_mod_mult #(
  parameter int         d  = `D,
  parameter bit [0:8+d] PQ = `PQ
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:7+d] a,
  input  logic [0:7+d] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:7+d] out
);
  localparam int            W    = 8 + d;
  localparam int            CW   = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        r_state, w_state_nxt;
  logic [0:W-1]  r_a, r_b, r_acc, w_a_shift;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready, r_out_valid;
  modular_shift #(.W(W), .P(PQ)) u_shift (.i_a(r_a), .o_y(w_a_shift));
  always_comb
    w_state_nxt = r_state == IDLE ? (in_valid ? BUSY : IDLE) :
                  r_state == BUSY ? (r_cnt == LAST ? DONE : BUSY) :
                  r_state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_a   <= a;
      r_b   <= b;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_acc <= r_acc ^ (r_b[0] ? r_a : '0);
      r_a   <= w_a_shift;
      r_b   <= {r_b[1:W-1], 1'b0};
      r_cnt <= r_cnt + 1'b1;
    end
`ifdef RAMBAM_MULT_SCRUB_EN
    else if (r_state == DONE && out_ready) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end
`endif
  end
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
`ifdef RAMBAM_MULT_SCRUB_EN
  assign out = r_out_valid ? r_acc : '0;
`else
  assign out = r_acc;
`endif
endmodule

// File: tb/tb_serial_mod_mult.sv
// tb_serial_mod_mult: directed scoreboard bench for serial_mod_mult with d=0 and the AES polynomial.
module tb_serial_mod_mult;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid;
    logic [0:7] a = '0;
    logic [0:7] b = '0;
    logic [0:7] out;
    int         total = 0;
    int         bad = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    serial_mod_mult u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    function automatic logic [0:7] rv(input logic [7:0] h);
        logic [0:7] v;
        for (int i = 0; i < 8; i++) v[i] = h[i];
        return v;
    endfunction

    function automatic logic [7:0] hx(input logic [0:7] v);
        logic [7:0] h;
        for (int i = 0; i < 8; i++) h[i] = v[i];
        return h;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (16'(x) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [7:0] ha, input logic [7:0] hb, input logic [7:0] e, input bit push);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        a = rv(ha);
        b = rv(hb);
        in_valid = 1'b1;
        if (push) sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = rv(8'($urandom));
        b = rv(8'($urandom));
        check("busy_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic recv(input int stall);
        int         lat;
        bit         ir, hold_bad;
        logic [7:0] held, e;
        lat = 0;
        ir = 1'b0;
        hold_bad = 1'b0;
        while (!out_valid && lat < 50) begin
            ir = ir | in_ready;
            @(negedge clk);
            lat++;
        end
        ir = ir | in_ready;
        check("latency", 32'(lat), 32'd8);
        check("ready_low_busy_done", 32'(ir), 32'd0);
        held = hx(out);
        for (int i = 0; i < stall; i++) begin
            a = rv(8'($urandom));
            @(negedge clk);
            hold_bad = hold_bad | !out_valid | (hx(out) !== held) | in_ready;
        end
        if (stall > 0) check("stall_hold", 32'(hold_bad), 32'd0);
        if (sb.size() > 0) e = sb.pop_front();
        else e = 'x;
        check("product", 32'(hx(out)), 32'(e));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
`ifdef RAMBAM_MULT_SCRUB_EN
        check("idle_out_scrub", 32'(hx(out)), 32'd0);
        check("idle_acc_scrub", 32'(u_dut.r_acc), 32'd0);
        check("idle_a_scrub", 32'(u_dut.r_a), 32'd0);
        check("idle_b_scrub", 32'(u_dut.r_b), 32'd0);
`else
        check("idle_out_last", 32'(hx(out)), 32'(e));
`endif
    endtask

    initial begin
        logic [7:0] pa[4];
        logic [7:0] pb[4];
        logic [7:0] e;
        int         idx, got, cyc, prev;
        bit         stale;
        pa = '{8'h57, 8'h87, 8'hA5, 8'h03};
        pb = '{8'h83, 8'h02, 8'h13, 8'hFF};

        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(hx(out)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(8'h57, 8'h83, 8'hC1, 1'b1);
        recv(0);
        send(8'h87, 8'h02, 8'h15, 1'b1);
        recv(0);
        send(8'hA5, 8'h01, 8'hA5, 1'b1);
        recv(0);
        send(8'hA5, 8'h00, 8'h00, 1'b1);
        recv(0);

        send(8'h57, 8'h83, 8'hC1, 1'b1);
        recv(20);

        idx = 0;
        got = 0;
        cyc = 0;
        prev = -1;
        out_ready = 1'b1;
        while (got < 4 && cyc < 200) begin
            if (out_valid) begin
                if (sb.size() > 0) e = sb.pop_front();
                else e = 'x;
                check("b2b_product", 32'(hx(out)), 32'(e));
                if (prev >= 0) check("b2b_spacing", 32'(cyc - prev), 32'd10);
                prev = cyc;
                got++;
            end
            if (in_ready && idx < 4) begin
                a = rv(pa[idx]);
                b = rv(pb[idx]);
                sb.push_back(gmul(pa[idx], pb[idx]));
                idx++;
                in_valid = 1'b1;
            end else begin
                a = rv(8'($urandom));
                b = rv(8'($urandom));
                in_valid = (idx < 4);
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b_count", 32'(got), 32'd4);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        send(8'h57, 8'h83, 8'hC1, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out", 32'(hx(out)), 32'd0);
        @(negedge clk);
        check("midrst_hold_out", 32'(hx(out)), 32'd0);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (10) begin
            @(negedge clk);
            stale = stale | out_valid;
        end
        check("no_stale_result", 32'(stale), 32'd0);
        send(8'h03, 8'h03, 8'h05, 1'b1);
        recv(0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
